// File: rtl/vga_scan_compositor.sv
// VGA scan-timing source and sprite compositor: generates h/v counters and syncs,
// merges drawer pixels by priority into registered RGB, and keeps a per-frame sticky collision flag.
module vga_scan_compositor #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter int          CLK_DIV  = 4,
    parameter logic [11:0] BG_RGB   = 12'hFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        game_reset,
    input  logic        goose,
    input  logic [11:0] goose_rgb,
    input  logic        obs,
    input  logic [11:0] obs_rgb,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        p_tick,
    output logic        frame_tick,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic        check_hit
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             hit_frame_q, hit_frame_d;
    logic             check_hit_q, check_hit_d;

    logic tick;
    logic h_wrap;
    logic v_wrap;
    logic video_on;
    logic overlap;
    logic frame_end;

    // Pixel clock enable and raster counters
    always_comb begin
        tick   = (div_q == DIV_LAST);
        h_wrap = (h_q == H_LAST);
        v_wrap = (v_q == V_LAST);
        div_d  = tick ? '0 : div_q + DIV_W'(1);
        h_d    = h_q;
        v_d    = v_q;
        if (tick) begin
            h_d = h_wrap ? 10'd0 : h_q + 10'd1;
            if (h_wrap) begin
                v_d = v_wrap ? 10'd0 : v_q + 10'd1;
            end
        end
    end

    // Output stage: drawer inputs are sampled at the end of the pixel while x/y is stable
    always_comb begin
        video_on  = (h_q < H_VIS) && (v_q < V_VIS);
        overlap   = tick && video_on && goose && obs;
        frame_end = tick && h_wrap && v_wrap;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        rgb_d     = rgb_q;
        if (tick) begin
            hsync_d = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
            vsync_d = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
            if (!video_on) begin
                rgb_d = 12'h000;
            end else if (goose) begin
                rgb_d = goose_rgb;
            end else if (obs) begin
                rgb_d = obs_rgb;
            end else begin
                rgb_d = BG_RGB;
            end
        end
    end

    // Collision flag only publishes at frame end so drawers see one value per frame
    always_comb begin
        hit_frame_d = hit_frame_q;
        check_hit_d = check_hit_q;
        if (overlap) begin
            hit_frame_d = 1'b1;
        end
        if (frame_end) begin
            check_hit_d = check_hit_q | hit_frame_q | overlap;
            hit_frame_d = 1'b0;
        end
        if (game_reset) begin
            check_hit_d = 1'b0;
            hit_frame_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q       <= '0;
            h_q         <= 10'd0;
            v_q         <= 10'd0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            rgb_q       <= 12'h000;
            hit_frame_q <= 1'b0;
            check_hit_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            h_q         <= h_d;
            v_q         <= v_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            rgb_q       <= rgb_d;
            hit_frame_q <= hit_frame_d;
            check_hit_q <= check_hit_d;
        end
    end

    assign x          = h_q;
    assign y          = v_q;
    assign p_tick     = tick;
    assign frame_tick = frame_end;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign rgb        = rgb_q;
    assign check_hit  = check_hit_q;

endmodule
